// File: rtl/ec_prod_sum_seq.sv
// Batch scheduler for the ec_prod_sum datapath: gates each NUM_PRODS-long
// accumulate/truncate/clear frame on operand availability and result space.
module ec_prod_sum_seq #(
  parameter int NUM_PRODS = 16,
  parameter int USED_W    = 9,
  parameter int BATCH_W   = 8
) (
  input  logic               f_clk,
  input  logic               clr,
  input  logic               start,
  input  logic [BATCH_W-1:0] num_batches,
  input  logic [USED_W-1:0]  data_A_rd_used,
  input  logic [USED_W-1:0]  data_B_rd_used,
  input  logic               result_wr_full,
  output logic               data_in_rd_req,
  output logic               trunc_ena,
  output logic               clear_ena,
  output logic               busy,
  output logic               done,
  output logic [BATCH_W-1:0] batch_cnt,
  output logic [7:0]         frame_cyc
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_DONE} state_t;

  localparam logic [USED_W-1:0] NP_U = USED_W'(NUM_PRODS);
  localparam logic [7:0]        NP8  = 8'(NUM_PRODS);

  state_t             state_q, state_d;
  logic [7:0]         cyc_q, cyc_d;
  logic [BATCH_W-1:0] nb_q, nb_d, batch_d;
  logic               ready, run_d;

  // Frame entry condition, examined only when a new frame could begin
  assign ready = (data_A_rd_used >= NP_U) && (data_B_rd_used >= NP_U) && !result_wr_full;

  always_comb begin
    state_d = state_q;
    cyc_d   = '0;
    batch_d = batch_cnt;
    nb_d    = nb_q;
    case (state_q)
      S_IDLE: if (start) begin
        nb_d    = num_batches;
        batch_d = '0;
        state_d = (num_batches == '0) ? S_DONE : S_WAIT;
      end
      S_WAIT: if (ready) state_d = S_RUN;
      S_RUN: begin
        if (cyc_q == NP8) begin
          batch_d = batch_cnt + 1'b1;
          if (batch_d == nb_q) state_d = S_DONE;
          else if (!ready)     state_d = S_WAIT;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign run_d = (state_d == S_RUN);

  // Outputs are decoded from the next state so they are all registered
  always_ff @(posedge f_clk) begin
    if (clr) begin
      state_q        <= S_IDLE;
      cyc_q          <= '0;
      nb_q           <= '0;
      batch_cnt      <= '0;
      data_in_rd_req <= 1'b0;
      trunc_ena      <= 1'b0;
      clear_ena      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      frame_cyc      <= '0;
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      nb_q           <= nb_d;
      batch_cnt      <= batch_d;
      data_in_rd_req <= run_d && (cyc_d < NP8);
      trunc_ena      <= run_d && (cyc_d >= 8'd2) && (cyc_d <= NP8 - 8'd4);
      clear_ena      <= (state_d == S_IDLE) || (state_d == S_DONE) ||
                        (run_d && (cyc_d == NP8 - 8'd1));
      busy           <= (state_d != S_IDLE);
      done           <= (state_d == S_DONE);
      frame_cyc      <= cyc_d;
    end
  end

endmodule

// File: tb/tb_ec_prod_sum_seq.sv
// Scoreboard bench for ec_prod_sum_seq: each start pushes the expected run
// outcome, each done pulse pops and checks it; frame shapes checked per cycle.
module tb_ec_prod_sum_seq;
  localparam int NP = 16;
  localparam int BW = 8;
  localparam int UW = 9;

  logic          f_clk = 1'b0;
  logic          clr = 1'b1, start = 1'b0, result_wr_full = 1'b0;
  logic [BW-1:0] num_batches = '0;
  logic [UW-1:0] used_a = '0, used_b = '0;
  logic          data_in_rd_req, trunc_ena, clear_ena, busy, done;
  logic [BW-1:0] batch_cnt;
  logic [7:0]    frame_cyc;

  ec_prod_sum_seq #(.NUM_PRODS(NP), .USED_W(UW), .BATCH_W(BW)) dut (
    .f_clk(f_clk), .clr(clr), .start(start), .num_batches(num_batches),
    .data_A_rd_used(used_a), .data_B_rd_used(used_b),
    .result_wr_full(result_wr_full), .data_in_rd_req(data_in_rd_req),
    .trunc_ena(trunc_ena), .clear_ena(clear_ena), .busy(busy), .done(done),
    .batch_cnt(batch_cnt), .frame_cyc(frame_cyc));

  always #5 f_clk = ~f_clk;

  typedef struct {int lat; int batches; int rd;} exp_t;
  exp_t q[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, rd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Idle/reset output image: {rd,trunc,clear,busy,done,batch_cnt,frame_cyc}
  function automatic logic [20:0] status();
    return {data_in_rd_req, trunc_ena, clear_ena, busy, done, batch_cnt, frame_cyc};
  endfunction
  localparam logic [20:0] RST_IMG = {5'b00100, 8'd0, 8'd0};

  // One clock; sample 1 ns after the edge, drain FIFOs, retire done events
  task automatic step();
    exp_t e;
    @(posedge f_clk); #1;
    cyc++;
    if (data_in_rd_req === 1'b1) begin
      rd_cnt++;
      if (used_a != 0) used_a--;
      if (used_b != 0) used_b--;
    end
    if (done === 1'b1) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("done_lat", cyc - start_cyc, e.lat);
        chk("batch_cnt", {24'd0, batch_cnt}, e.batches);
        chk("rd_total", rd_cnt, e.rd);
      end
    end
  endtask

  task automatic do_start(input int nb, input int lat);
    exp_t e;
    e.lat = lat; e.batches = nb; e.rd = nb * NP;
    q.push_back(e);
    num_batches = BW'(nb);
    start = 1'b1;
    start_cyc = cyc; rd_cnt = 0;
    step();
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin step(); n++; end
    if (q.size() != 0) begin
      chk("timeout", 0, 1);
      q.delete();
    end
    step();
  endtask

  initial begin
    int c;
    logic [3:0] ex;
    // Reset and idle
    repeat (2) step();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); chk("idle", status(), RST_IMG); end

    // Single batch, per-cycle frame shape
    used_a = 16; used_b = 16;
    do_start(1, 19);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) step();
      c = k - 2;
      ex[3] = (k >= 2 && k <= 17);
      ex[2] = (k >= 2 && k <= 18 && c >= 2 && c <= 12);
      ex[1] = (k == 1) ? 1'b0 : (k <= 18) ? (c == 15) : 1'b1;
      ex[0] = (k == 19);
      chk($sformatf("frame_k%0d", k), {data_in_rd_req, trunc_ena, clear_ena, done}, ex);
      chk("frame_cyc", frame_cyc, (k >= 2 && k <= 18) ? c : 0);
    end
    chk("sb_empty1", q.size(), 0);

    // Back-to-back three batches from 48 words
    used_a = 48; used_b = 48;
    do_start(3, 53);
    drain(100);
    chk("drained_a", used_a, 0);

    // Starvation on operand count
    used_a = 15; used_b = 16;
    do_start(1, 28);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("starve_wait", {busy, data_in_rd_req, trunc_ena, clear_ena}, 4'b1000);
    end
    used_a = 16;
    step();
    chk("starve_run", {data_in_rd_req, frame_cyc}, {1'b1, 8'd0});
    drain(100);

    // Starvation on result full
    used_a = 16; used_b = 16; result_wr_full = 1'b1;
    do_start(1, 24);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("full_wait", {busy, data_in_rd_req}, 2'b10);
    end
    result_wr_full = 1'b0;
    step();
    chk("full_run", data_in_rd_req, 1);
    drain(100);

    // Mid-run clr at c=7 of batch 2
    used_a = 200; used_b = 200;
    do_start(3, 53);
    repeat (25) step();
    chk("pre_clr_cyc", {batch_cnt, frame_cyc}, {8'd1, 8'd7});
    clr = 1'b1;
    q.delete();
    step();
    clr = 1'b0;
    chk("clr_img", status(), RST_IMG);
    repeat (5) begin step(); chk("post_clr", status(), RST_IMG); end
    do_start(1, 19);
    drain(100);

    // num_batches = 0
    do_start(0, 1);
    chk("nb0_done", {done, busy, clear_ena, data_in_rd_req}, 4'b1110);
    drain(10);

    // start while busy is ignored
    do_start(2, 36);
    repeat (10) step();
    num_batches = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    drain(100);

    // start together with clr stays idle
    clr = 1'b1; start = 1'b1; num_batches = 8'd1;
    step();
    clr = 1'b0; start = 1'b0;
    chk("clr_start", status(), RST_IMG);
    step();
    chk("clr_start2", status(), RST_IMG);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ec_prod_sum_seq.md
# ec_prod_sum_seq

Fast-clock sequencer for the error-correcting product-sum datapath. It replaces hand-driven `data_in_rd_req`, `trunc_ena` and `clear_ena` sequencing with a batch scheduler. The scheduler waits until both operand FIFOs hold a full batch and the result FIFO has room, then plays one `NUM_PRODS`-long accumulate/truncate/clear frame per batch. It sits between the input/result FIFO status ports and the control inputs of `ec_prod_sum` in the `f_clk` domain.

## Interface
Parameters:
- `NUM_PRODS`, 16: products per batch (frame length). Legal range is 8..255.
- `USED_W`, 9: width of the FIFO used-word counts.
- `BATCH_W`, 8: width of the batch count and counter.

Ports:
- `f_clk`, in, 1: the single clock. All logic runs on the rising edge.
- `clr`, in, 1: reset, synchronous, active-high. It has priority over every other input.
- `start`, in, 1: single-cycle request to begin a run. Ignored unless the block is in IDLE.
- `num_batches`, in, `BATCH_W`: number of batches to run, latched on an accepted `start`.
- `data_A_rd_used`, in, `USED_W`: operand-A FIFO read-side word count.
- `data_B_rd_used`, in, `USED_W`: operand-B FIFO read-side word count.
- `result_wr_full`, in, 1: result FIFO full flag, write side.
- `data_in_rd_req`, out, 1: read strobe to both operand FIFOs.
- `trunc_ena`, out, 1: datapath truncation enable.
- `clear_ena`, out, 1: accumulator clear enable.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a run completes.
- `batch_cnt`, out, `BATCH_W`: number of batches completed in the current run.
- `frame_cyc`, out, 8: current frame cycle index. Reads 0 outside RUN.

## Operation
- Every output is registered.
- Reset values: `data_in_rd_req`=0, `trunc_ena`=0, `clear_ena`=1, `busy`=0, `done`=0, `batch_cnt`=0, `frame_cyc`=0, state=IDLE.
- States:
  - IDLE: `clear_ena`=1, all other strobes 0. On `start`, latch `num_batches` into `nb_q` and clear `batch_cnt`. Go to DONE if `num_batches`=0, otherwise go to WAIT.
  - WAIT: all strobes 0 and `clear_ena`=0. Go to RUN when all of the following hold in the same cycle:
    - `data_A_rd_used` ≥ `NUM_PRODS`
    - `data_B_rd_used` ≥ `NUM_PRODS`
    - `!result_wr_full`
  - RUN: `frame_cyc` c counts from 0 to `NUM_PRODS`, one frame per batch (`NUM_PRODS`+1 cycles).
    - `data_in_rd_req` = (c < `NUM_PRODS`).
    - `trunc_ena` = (2 ≤ c ≤ `NUM_PRODS`−4).
    - `clear_ena` = (c == `NUM_PRODS`−1).
    - At c = `NUM_PRODS`, `batch_cnt` increments. If `batch_cnt`+1 == `nb_q`, go to DONE.
    - Otherwise re-evaluate the WAIT condition in that same cycle. If it holds, go directly to RUN c=0 (back-to-back frames, no bubble); if not, go to WAIT.
  - DONE: `done`=1 for exactly one cycle and `clear_ena`=1. Next state is IDLE. `batch_cnt` holds its final value until the next accepted `start`.
- Once a frame has started it always completes. FIFO counts and `result_wr_full` are examined only at frame entry.
- Arithmetic rules:
  - Comparisons against `NUM_PRODS` are unsigned.
  - `batch_cnt` never wraps within a run because it stops at `nb_q`.
  - `num_batches` = 2^`BATCH_W`−1 is legal.
- Boundary conditions:
  - `start` while busy: ignored; `nb_q` is unchanged.
  - `start` and `clr` in the same cycle: `clr` wins and the block stays in IDLE.
  - `clr` mid-frame: all outputs return to their reset values on the next edge. The partial frame is abandoned, and no `done` pulse is produced.
  - FIFO count exactly `NUM_PRODS`: satisfies the WAIT condition.
  - `result_wr_full` asserting mid-frame: has no effect until the next frame entry.

## Timing
- `start` sampled high at edge t: state is WAIT from t+1.
- If the WAIT condition holds at t+1, RUN c=0 begins at t+2 with `data_in_rd_req`=1.
- Per-batch latency is `NUM_PRODS`+1 cycles when data is already present.
- Total run time with data present is 1 (WAIT) + N×(`NUM_PRODS`+1) + 1 (DONE) cycles after `start` acceptance. For the default with N=3, that is 53 cycles.
- `data_in_rd_req` is high for exactly `NUM_PRODS` cycles per frame. Operand FIFO counts drop by `NUM_PRODS` per batch.
- `clear_ena` rises in the same cycle as the last `data_in_rd_req` of a frame and falls at c=`NUM_PRODS`.

## Test plan
- Reset and idle:
  - Stimulus: assert `clr` for 2 cycles, release it, hold `start`=0.
  - Required response: `clear_ena`=1, `busy`=0, all other outputs 0, stable for 20 cycles.
- Single batch, data present:
  - Stimulus: A/B used=16, `start` with `num_batches`=1.
  - Required response: `data_in_rd_req` high for 16 cycles starting at t+2; `trunc_ena` high for c=2..12; `clear_ena` high at c=15; `done` pulse at t+19; `batch_cnt`=1.
- Back-to-back batches:
  - Stimulus: used=48, `num_batches`=3.
  - Required response: 48 total `data_in_rd_req` cycles with one gap cycle per frame; `done` at cycle 53 after acceptance.
- Starvation:
  - Stimulus: used=15 for 10 cycles, then 16.
  - Required response: the block stays in WAIT with no strobes, and RUN starts on the cycle after the count reaches 16. Repeat with `result_wr_full`=1: the block stays in WAIT until the flag drops.
- Mid-run `clr`:
  - Stimulus: assert `clr` at c=7 of batch 2.
  - Required response: next-cycle reset values, no `done`, and a fresh `start` runs normally.
- Edge inputs:
  - Stimulus 1: `num_batches`=0. Required response: `done` pulse at t+1 and zero `data_in_rd_req` cycles.
  - Stimulus 2: `start` while busy. Required response: ignored, with the batch total unchanged.
